hazard_scoreboard: RTL and testbench
====================================

Name: hazard_scoreboard

Overview:
Parametrised scoreboard-based hazard detection unit for the in-order pipeline; generalises the fixed EXE/MEM destination compare to N source operands and a configurable issue-to-writeback distance. A per-register countdown tracks in-flight writes, which resolves RAW hazards in both forwarding and non-forwarding modes and gives load-use stalls exact timing. It sits in ID and drives the stall to IF/ID and the bubble into EXE. It also exports a busy vector and a saturating stall-cycle counter for performance monitoring.

Parameters:
REG_ADDR_W, 5, register address width; 2**REG_ADDR_W tracked registers; register 0 is never tracked
NUM_SRC, 2, number of source operands checked per instruction
WB_DIST, 2, cycles after issue during which the result is not yet readable from the register file; legal range 1..15
LOAD_FWD_AT, 1, a load result is forwardable once its countdown is <= this value; legal range 0..WB_DIST-1
STALL_CNT_W, 16, width of stall_cycles

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-high reset
en_fwd  in  1  1 = forwarding enabled, 0 = wait for writeback
freeze  in  1  downstream pipeline freeze; holds all scoreboard state
flush  in  1  kills the instruction in ID this cycle
issue_valid  in  1  ID holds a valid instruction
src_addr  in  NUM_SRC*REG_ADDR_W  packed source addresses; operand i is at bits [i*REG_ADDR_W +: REG_ADDR_W]
src_valid  in  NUM_SRC  operand i is actually read (replaces a fixed two-register flag)
dest_addr  in  REG_ADDR_W  destination of the ID instruction
wb_en  in  1  ID instruction writes dest_addr
mem_r_en  in  1  ID instruction is a load
hazard_detected  out  1  combinational stall request
issue_accept  out  1  combinational: the instruction leaves ID this cycle
busy_vec  out  2**REG_ADDR_W  bit r = registered count[r] != 0
stall_cycles  out  STALL_CNT_W  registered, saturating count of hazard stall cycles

Behaviour:
- State per register r (1..2**REG_ADDR_W-1): count[r], clog2(WB_DIST+1) bits, and is_load[r], 1 bit. Register 0 is hardwired to count 0, is_load 0.
- Reset (rst=1 at a clk edge): all count=0, all is_load=0, stall_cycles=0. Consequently busy_vec=0, hazard_detected=0 and issue_accept=issue_valid&!freeze&!flush.
- Reset has priority over every other input, including mid-countdown state.
- Per-operand hazard h_i (operand i with src_valid[i]=1, address a): h_i = (count[a]!=0) when en_fwd=0; h_i = is_load[a] & (count[a] > LOAD_FWD_AT) when en_fwd=1. Address 0 never hazards.
- hazard_detected = issue_valid & (OR of h_i). Evaluated from current registered state only; the same-cycle issue is not visible to it.
- issue_accept = issue_valid & !hazard_detected & !freeze & !flush.
- Each clk edge with freeze=0, per register r:
  - if issue_accept & wb_en & dest_addr==r & r!=0: count[r] <= WB_DIST, is_load[r] <= mem_r_en (set wins over decrement);
  - else if count[r]!=0: count[r] <= count[r]-1, and is_load[r] <= 0 when reaching 0.
- freeze=1: count, is_load and stall_cycles all hold; hazard_detected is still driven.
- WAW: a new issue to a pending register overwrites count and is_load.
- flush: no issue accepted and stall_cycles not incremented; countdowns of in-flight instructions continue.
- stall_cycles increments by 1 when issue_valid & hazard_detected & !flush & !freeze; it holds at all-ones.
- Latency: the producer becomes visible to hazard checks in the cycle after issue_accept. With en_fwd=0, a dependent instruction stalls exactly WB_DIST cycles. With en_fwd=1, a load-use dependence stalls exactly WB_DIST-LOAD_FWD_AT cycles and an ALU dependence stalls 0 cycles.

Test Plan:
- Non-forwarding stall: defaults, en_fwd=0; issue ALU write r3 at cycle 0, then a consumer with src0=r3 at cycle 1 -> hazard_detected=1 in cycles 1-2, issue_accept at cycle 3, stall_cycles=2, busy_vec[3] high in cycles 1-2.
- Forwarding: en_fwd=1; ALU producer of r3 followed by consumer -> no stall. Load producer of r5 followed by consumer of r5 -> one stall cycle (cycle 1), accept at cycle 2.
- Operand masking and register 0: src1=r3 with src_valid=2'b01 -> no stall. Producer writing r0 with wb_en=1 -> busy_vec stays 0 and a consumer of r0 never stalls.
- Freeze and flush: assert freeze for 3 cycles while count[r3]=2 -> count holds and busy_vec[3] stays high, resuming after release. flush during a hazard -> issue_accept=0 and stall_cycles unchanged.
- WAW and reset: load r7, then ALU r7 one cycle later once it is accepted -> is_load[7]=0, so an en_fwd=1 consumer does not stall. rst asserted mid-countdown -> busy_vec=0 and stall_cycles=0 on the next cycle.
- Parametrisation: NUM_SRC=3, WB_DIST=4, LOAD_FWD_AT=2; load r9 with src2=r9 -> 2 stall cycles with en_fwd=1, 4 with en_fwd=0. Force stall_cycles to saturate -> it holds at all-ones.

Source files
------------

// File: rtl/hazard_scoreboard_if.sv
// ID-stage issue interface: the instruction presented for issue and the scoreboard's verdict.
// issue_valid is held by ID; issue_accept in the same cycle means the instruction leaves ID.
interface hazard_scoreboard_if #(
    parameter int REG_ADDR_W = 5,
    parameter int NUM_SRC    = 2
) ();
    logic                          issue_valid;
    logic [NUM_SRC*REG_ADDR_W-1:0] src_addr;
    logic [NUM_SRC-1:0]            src_valid;
    logic [REG_ADDR_W-1:0]         dest_addr;
    logic                          wb_en;
    logic                          mem_r_en;
    logic                          hazard_detected;
    logic                          issue_accept;

    modport master (
        output issue_valid, src_addr, src_valid, dest_addr, wb_en, mem_r_en,
        input  hazard_detected, issue_accept
    );

    modport slave (
        input  issue_valid, src_addr, src_valid, dest_addr, wb_en, mem_r_en,
        output hazard_detected, issue_accept
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// Scoreboard hazard unit: per-register countdown of in-flight writes resolves RAW stalls
// with or without forwarding, and counts stall cycles for performance monitoring.
module hazard_scoreboard #(
    parameter int REG_ADDR_W  = 5,
    parameter int NUM_SRC     = 2,
    parameter int WB_DIST     = 2,
    parameter int LOAD_FWD_AT = 1,
    parameter int STALL_CNT_W = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        en_fwd,
    input  logic                        freeze,
    input  logic                        flush,
    hazard_scoreboard_if.slave          id_if,
    output logic [2**REG_ADDR_W-1:0]    busy_vec,
    output logic [STALL_CNT_W-1:0]      stall_cycles
);
    localparam int NUM_REGS = 2**REG_ADDR_W;
    localparam int CNT_W    = $clog2(WB_DIST + 1);
    localparam logic [CNT_W-1:0] CNT_START = CNT_W'(WB_DIST);
    localparam logic [CNT_W-1:0] FWD_AT    = CNT_W'(LOAD_FWD_AT);

    logic [CNT_W-1:0]       count_q   [NUM_REGS];
    logic [CNT_W-1:0]       count_d   [NUM_REGS];
    logic                   is_load_q [NUM_REGS];
    logic                   is_load_d [NUM_REGS];
    logic [STALL_CNT_W-1:0] stall_q;
    logic [STALL_CNT_W-1:0] stall_d;

    logic [REG_ADDR_W-1:0]  src_a [NUM_SRC];
    logic [NUM_SRC-1:0]     src_hazard;
    logic                   hazard;
    logic                   accept;

    // Only registered state is consulted; the instruction issuing this cycle is not yet visible.
    always_comb begin
        src_hazard = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            src_a[i] = id_if.src_addr[i*REG_ADDR_W +: REG_ADDR_W];
            if (id_if.src_valid[i] && (src_a[i] != '0)) begin
                if (en_fwd) begin
                    src_hazard[i] = is_load_q[src_a[i]] && (count_q[src_a[i]] > FWD_AT);
                end else begin
                    src_hazard[i] = (count_q[src_a[i]] != '0);
                end
            end
        end
    end

    assign hazard = id_if.issue_valid & (|src_hazard);
    assign accept = id_if.issue_valid & ~hazard & ~freeze & ~flush;

    assign id_if.hazard_detected = hazard;
    assign id_if.issue_accept    = accept;
    assign stall_cycles          = stall_q;

    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            busy_vec[r] = (count_q[r] != '0);
        end
    end

    always_comb begin
        count_d   = count_q;
        is_load_d = is_load_q;
        stall_d   = stall_q;
        count_d[0]   = '0;
        is_load_d[0] = 1'b0;
        if (!freeze) begin
            for (int r = 1; r < NUM_REGS; r++) begin
                // A new write to the register restarts its countdown (WAW overwrite).
                if (accept && id_if.wb_en && (id_if.dest_addr == REG_ADDR_W'(r))) begin
                    count_d[r]   = CNT_START;
                    is_load_d[r] = id_if.mem_r_en;
                end else if (count_q[r] != '0) begin
                    count_d[r] = count_q[r] - 1'b1;
                    if (count_q[r] == CNT_W'(1)) begin
                        is_load_d[r] = 1'b0;
                    end
                end
            end
            if (hazard && !flush && (stall_q != '1)) begin
                stall_d = stall_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                count_q[r]   <= '0;
                is_load_q[r] <= 1'b0;
            end
            stall_q <= '0;
        end else begin
            count_q   <= count_d;
            is_load_q <= is_load_d;
            stall_q   <= stall_d;
        end
    end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: default build plus a 3-source, WB_DIST=4 build
// with a 3-bit stall counter; expected per-cycle responses flow through queues to a monitor.
module tb_hazard_scoreboard;
  logic clk;
  logic rst_a, fwd_a, frz_a, fl_a;
  logic rst_b, fwd_b, frz_b, fl_b;
  logic [31:0] busy_a, busy_b;
  logic [15:0] stall_a;
  logic [2:0]  stall_b;

  int checks;
  int errors;
  int vec_a;
  int vec_b;

  logic [49:0] exp_a_q[$];
  logic [36:0] exp_b_q[$];

  hazard_scoreboard_if #(.REG_ADDR_W(5), .NUM_SRC(2)) a_if ();
  hazard_scoreboard_if #(.REG_ADDR_W(5), .NUM_SRC(3)) b_if ();

  hazard_scoreboard #(
    .REG_ADDR_W(5), .NUM_SRC(2), .WB_DIST(2), .LOAD_FWD_AT(1), .STALL_CNT_W(16)
  ) dut_a (
    .clk(clk), .rst(rst_a), .en_fwd(fwd_a), .freeze(frz_a), .flush(fl_a),
    .id_if(a_if.slave), .busy_vec(busy_a), .stall_cycles(stall_a)
  );

  hazard_scoreboard #(
    .REG_ADDR_W(5), .NUM_SRC(3), .WB_DIST(4), .LOAD_FWD_AT(2), .STALL_CNT_W(3)
  ) dut_b (
    .clk(clk), .rst(rst_b), .en_fwd(fwd_b), .freeze(frz_b), .flush(fl_b),
    .id_if(b_if.slave), .busy_vec(busy_b), .stall_cycles(stall_b)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // driver tasks: apply one cycle of inputs just after the edge and queue the expected response
  task automatic step_a(input logic chk, input logic rs, input logic fwd, input logic frz,
                        input logic fl, input logic iv, input logic [4:0] s0, input logic [4:0] s1,
                        input logic [1:0] sv, input logic [4:0] d, input logic wb, input logic ld,
                        input logic hz, input logic acc, input logic [31:0] busy,
                        input logic [15:0] st);
    @(posedge clk);
    #1;
    rst_a = rs; fwd_a = fwd; frz_a = frz; fl_a = fl;
    a_if.issue_valid = iv;
    a_if.src_addr    = {s1, s0};
    a_if.src_valid   = sv;
    a_if.dest_addr   = d;
    a_if.wb_en       = wb;
    a_if.mem_r_en    = ld;
    if (chk) exp_a_q.push_back({hz, acc, busy, st});
  endtask

  task automatic step_b(input logic chk, input logic rs, input logic fwd, input logic iv,
                        input logic [4:0] s0, input logic [4:0] s1, input logic [4:0] s2,
                        input logic [2:0] sv, input logic [4:0] d, input logic wb, input logic ld,
                        input logic hz, input logic acc, input logic [31:0] busy,
                        input logic [2:0] st);
    @(posedge clk);
    #1;
    rst_b = rs; fwd_b = fwd;
    b_if.issue_valid = iv;
    b_if.src_addr    = {s2, s1, s0};
    b_if.src_valid   = sv;
    b_if.dest_addr   = d;
    b_if.wb_en       = wb;
    b_if.mem_r_en    = ld;
    if (chk) exp_b_q.push_back({hz, acc, busy, st});
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    logic [49:0] got_a, e_a;
    logic [36:0] got_b, e_b;
    if (exp_a_q.size() > 0) begin
      e_a   = exp_a_q.pop_front();
      got_a = {a_if.hazard_detected, a_if.issue_accept, busy_a, stall_a};
      checks++;
      if (got_a !== e_a) begin
        errors++;
        $display("FAIL dut_a vec%0d: got hz=%0b acc=%0b busy=%h stall=%0d, expected hz=%0b acc=%0b busy=%h stall=%0d",
                 vec_a, got_a[49], got_a[48], got_a[47:16], got_a[15:0],
                 e_a[49], e_a[48], e_a[47:16], e_a[15:0]);
      end
      vec_a++;
    end
    if (exp_b_q.size() > 0) begin
      e_b   = exp_b_q.pop_front();
      got_b = {b_if.hazard_detected, b_if.issue_accept, busy_b, stall_b};
      checks++;
      if (got_b !== e_b) begin
        errors++;
        $display("FAIL dut_b vec%0d: got hz=%0b acc=%0b busy=%h stall=%0d, expected hz=%0b acc=%0b busy=%h stall=%0d",
                 vec_b, got_b[36], got_b[35], got_b[34:3], got_b[2:0],
                 e_b[36], e_b[35], e_b[34:3], e_b[2:0]);
      end
      vec_b++;
    end
  end

  initial begin
    checks = 0; errors = 0; vec_a = 0; vec_b = 0;
    rst_a = 1'b1; fwd_a = 1'b0; frz_a = 1'b0; fl_a = 1'b0;
    rst_b = 1'b1; fwd_b = 1'b0; frz_b = 1'b0; fl_b = 1'b0;
    a_if.issue_valid = 1'b0; a_if.src_addr = '0; a_if.src_valid = '0;
    a_if.dest_addr = '0; a_if.wb_en = 1'b0; a_if.mem_r_en = 1'b0;
    b_if.issue_valid = 1'b0; b_if.src_addr = '0; b_if.src_valid = '0;
    b_if.dest_addr = '0; b_if.wb_en = 1'b0; b_if.mem_r_en = 1'b0;

    // ---- dut_a: chk rs fwd frz fl iv s0 s1 sv dest wb ld | hz acc busy stall
    step_a(0,1,0,0,0, 0, 0,0,2'b00, 0,0,0, 0,0,32'h0,0);
    step_a(1,0,0,0,0, 1, 0,0,2'b00, 0,0,0, 0,1,32'h0,0);     // reset state
    // non-forwarding: ALU r3 then consumer stalls WB_DIST cycles
    step_a(1,0,0,0,0, 1, 0,0,2'b00, 3,1,0, 0,1,32'h0,0);
    step_a(1,0,0,0,0, 1, 3,0,2'b01, 0,0,0, 1,0,32'h8,0);
    step_a(1,0,0,0,0, 1, 3,0,2'b01, 0,0,0, 1,0,32'h8,1);
    step_a(1,0,0,0,0, 1, 3,0,2'b01, 0,0,0, 0,1,32'h0,2);
    // forwarding: ALU r3 no stall; load r5 one stall
    step_a(1,0,1,0,0, 1, 0,0,2'b00, 3,1,0, 0,1,32'h0,2);
    step_a(1,0,1,0,0, 1, 3,0,2'b01, 0,0,0, 0,1,32'h8,2);
    step_a(1,0,1,0,0, 1, 0,0,2'b00, 5,1,1, 0,1,32'h8,2);
    step_a(1,0,1,0,0, 1, 5,0,2'b01, 0,0,0, 1,0,32'h20,2);
    step_a(1,0,1,0,0, 1, 5,0,2'b01, 0,0,0, 0,1,32'h20,3);
    // operand masking and register 0
    step_a(1,0,0,0,0, 1, 0,0,2'b00, 3,1,0, 0,1,32'h0,3);
    step_a(1,0,0,0,0, 1, 0,3,2'b01, 0,0,0, 0,1,32'h8,3);
    step_a(1,0,0,0,0, 1, 0,0,2'b00, 0,1,0, 0,1,32'h8,3);
    step_a(1,0,0,0,0, 1, 0,0,2'b11, 0,0,0, 0,1,32'h0,3);
    // freeze holds countdown and counter; flush suppresses counting
    step_a(1,0,0,0,0, 1, 0,0,2'b00, 3,1,0, 0,1,32'h0,3);
    step_a(1,0,0,1,0, 1, 3,0,2'b01, 0,0,0, 1,0,32'h8,3);
    step_a(1,0,0,1,0, 1, 3,0,2'b01, 0,0,0, 1,0,32'h8,3);
    step_a(1,0,0,1,0, 1, 3,0,2'b01, 0,0,0, 1,0,32'h8,3);
    step_a(1,0,0,0,0, 1, 3,0,2'b01, 0,0,0, 1,0,32'h8,3);
    step_a(1,0,0,0,1, 1, 3,0,2'b01, 0,0,0, 1,0,32'h8,4);
    step_a(1,0,0,0,0, 1, 3,0,2'b01, 0,0,0, 0,1,32'h0,4);
    step_a(1,0,0,1,0, 1, 0,0,2'b00, 3,1,0, 0,0,32'h0,4);     // frozen producer not issued
    step_a(1,0,0,0,0, 1, 3,0,2'b01, 0,0,0, 0,1,32'h0,4);
    // WAW: load r7 overwritten by ALU r7
    step_a(1,0,1,0,0, 1, 0,0,2'b00, 7,1,1, 0,1,32'h0,4);
    step_a(1,0,1,0,0, 1, 0,0,2'b00, 7,1,0, 0,1,32'h80,4);
    step_a(1,0,1,0,0, 1, 7,0,2'b01, 0,0,0, 0,1,32'h80,4);
    // reset mid-countdown
    step_a(1,0,0,0,0, 1, 0,0,2'b00, 3,1,0, 0,1,32'h80,4);
    step_a(1,1,0,0,0, 1, 3,0,2'b01, 0,0,0, 1,0,32'h8,4);
    step_a(1,0,0,0,0, 1, 3,0,2'b01, 0,0,0, 0,1,32'h0,0);
    // hazard on operand 1
    step_a(1,0,0,0,0, 1, 0,0,2'b00, 9,1,0, 0,1,32'h0,0);
    step_a(1,0,0,0,0, 1, 0,9,2'b10, 0,0,0, 1,0,32'h200,0);
    step_a(1,0,0,0,0, 1, 0,9,2'b10, 0,0,0, 1,0,32'h200,1);
    step_a(1,0,0,0,0, 1, 0,9,2'b10, 0,0,0, 0,1,32'h0,2);
    // no valid instruction: no hazard, no counting
    step_a(1,0,0,0,0, 1, 0,0,2'b00, 3,1,0, 0,1,32'h0,2);
    step_a(1,0,0,0,0, 0, 3,0,2'b01, 0,0,0, 0,0,32'h8,2);
    step_a(1,0,0,0,0, 0, 3,0,2'b01, 0,0,0, 0,0,32'h8,2);
    step_a(1,0,0,0,0, 0, 0,0,2'b00, 0,0,0, 0,0,32'h0,2);

    // ---- dut_b: chk rs fwd iv s0 s1 s2 sv dest wb ld | hz acc busy stall
    step_b(0,1,0, 0, 0,0,0,3'b000, 0,0,0, 0,0,32'h0,0);
    step_b(1,0,1, 1, 0,0,0,3'b000, 9,1,1, 0,1,32'h0,0);
    step_b(1,0,1, 1, 0,0,9,3'b100, 0,0,0, 1,0,32'h200,0);
    step_b(1,0,1, 1, 0,0,9,3'b100, 0,0,0, 1,0,32'h200,1);
    step_b(1,0,1, 1, 0,0,9,3'b100, 0,0,0, 0,1,32'h200,2);
    step_b(1,0,1, 0, 0,0,0,3'b000, 0,0,0, 0,0,32'h200,2);
    step_b(1,0,0, 1, 0,0,0,3'b000, 9,1,1, 0,1,32'h0,2);
    step_b(1,0,0, 1, 0,0,9,3'b100, 0,0,0, 1,0,32'h200,2);
    step_b(1,0,0, 1, 0,0,9,3'b100, 0,0,0, 1,0,32'h200,3);
    step_b(1,0,0, 1, 0,0,9,3'b100, 0,0,0, 1,0,32'h200,4);
    step_b(1,0,0, 1, 0,0,9,3'b100, 0,0,0, 1,0,32'h200,5);
    step_b(1,0,0, 1, 0,0,9,3'b100, 0,0,0, 0,1,32'h0,6);
    // saturation of the 3-bit stall counter
    step_b(1,0,0, 1, 0,0,0,3'b000, 9,1,0, 0,1,32'h0,6);
    step_b(1,0,0, 1, 0,0,9,3'b100, 0,0,0, 1,0,32'h200,6);
    step_b(1,0,0, 1, 0,0,9,3'b100, 0,0,0, 1,0,32'h200,7);
    step_b(1,0,0, 1, 0,0,9,3'b100, 0,0,0, 1,0,32'h200,7);
    step_b(1,0,0, 1, 0,0,9,3'b100, 0,0,0, 1,0,32'h200,7);
    step_b(1,0,0, 1, 0,0,9,3'b100, 0,0,0, 0,1,32'h0,7);

    // final report
    repeat (2) @(negedge clk);
    #1;
    if ((exp_a_q.size() != 0) || (exp_b_q.size() != 0)) begin
      errors++;
      $display("FAIL drain: %0d/%0d expected entries left, required 0/0",
               exp_a_q.size(), exp_b_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
